// File: rtl/switch_egress_if.sv
// Request/grant and crossbar-select bundle between the ingress ports,
// the egress scheduler and the egress muxes.
interface switch_egress_if #(
  parameter int unsigned NUM_PORTS = 4
);
  logic [NUM_PORTS-1:0]           req_i;
  logic [NUM_PORTS*NUM_PORTS-1:0] target_i;
  logic [NUM_PORTS-1:0]           prio_i;
  logic [NUM_PORTS-1:0]           grant_o;
  logic [NUM_PORTS*NUM_PORTS-1:0] out_sel_o;
  logic [NUM_PORTS-1:0]           out_busy_o;
  logic [NUM_PORTS-1:0]           aged_o;
  logic [NUM_PORTS-1:0]           zero_tgt_o;

  modport master (
    output req_i, target_i, prio_i,
    input  grant_o, out_sel_o, out_busy_o, aged_o, zero_tgt_o
  );

  modport slave (
    input  req_i, target_i, prio_i,
    output grant_o, out_sel_o, out_busy_o, aged_o, zero_tgt_o
  );
endinterface

// File: rtl/switch_egress_scheduler.sv
// Atomic multicast egress allocator for the 4-port crossbar with timed path hold.
// Optional anti-starvation aging and egress reservation under macro STARVE_GUARD_EN.
module switch_egress_scheduler #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned XFER_CYCLES = 2,
  parameter int unsigned AGE_LIMIT   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  switch_egress_if.slave  bus
);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned AGE_W  = 8;
  localparam int unsigned NPASS  = 3;
  localparam logic [CNT_W-1:0] XFER_LD = CNT_W'(XFER_CYCLES);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  logic [CNT_W-1:0]               busy_cnt [NUM_PORTS];
  logic [PTR_W-1:0]               rr_ptr;
  logic [NUM_PORTS-1:0]           grant_q;
  logic [NUM_PORTS-1:0]           zero_q;
  logic [NUM_PORTS-1:0]           busy_q;
  logic [NUM_PORTS*NUM_PORTS-1:0] sel_q;

  logic [NUM_PORTS-1:0] tgt [NUM_PORTS];
  logic [NUM_PORTS-1:0] free_c, elig_c, zero_c, aged_c;
  logic [NUM_PORTS-1:0] gnt_d, claim_d, resv_d;
  logic [NUM_PORTS-1:0] sel_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] pass_mask [NPASS];
  logic [PTR_W-1:0]     rr_d, idx;

  // Per-port decode of targets, egress availability and request eligibility
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      tgt[i]    = bus.target_i[NUM_PORTS*i +: NUM_PORTS];
      free_c[i] = (busy_cnt[i] == '0);
      elig_c[i] = bus.req_i[i] & (|tgt[i]) & ~grant_q[i];
      zero_c[i] = bus.req_i[i] & ~(|tgt[i]);
    end
  end

  // Greedy pass-ordered allocation; a port wins only if its whole mask is available
  always_comb begin
    gnt_d   = '0;
    claim_d = '0;
    resv_d  = '0;
    rr_d    = rr_ptr;
    idx     = '0;
    for (int j = 0; j < NUM_PORTS; j++) sel_d[j] = '0;
    pass_mask[0] = elig_c & aged_c;
    pass_mask[1] = elig_c & bus.prio_i & ~aged_c;
    pass_mask[2] = elig_c & ~bus.prio_i & ~aged_c;
    for (int p = 0; p < NPASS; p++) begin
      // Aged ports left unserved keep their free egresses away from everyone else
      if (p == 1) begin
        for (int i = 0; i < NUM_PORTS; i++)
          if (pass_mask[0][i] && !gnt_d[i]) resv_d = resv_d | (tgt[i] & free_c);
      end
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = PTR_W'(rr_ptr + PTR_W'(k));
        if (pass_mask[p][idx] &&
            ((tgt[idx] & ~(free_c & ~claim_d & ~resv_d)) == '0)) begin
          gnt_d[idx] = 1'b1;
          claim_d    = claim_d | tgt[idx];
          rr_d       = PTR_W'(idx + PTR_W'(1));
          for (int j = 0; j < NUM_PORTS; j++)
            if (tgt[idx][j]) sel_d[j] = NUM_PORTS'(1) << idx;
        end
      end
    end
  end

`ifdef STARVE_GUARD_EN
  logic [AGE_W-1:0]     age_q [NUM_PORTS];
  logic [AGE_W-1:0]     age_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] aged_q, aged_d;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      age_d[i] = age_q[i];
      if (!bus.req_i[i] || gnt_d[i])              age_d[i] = '0;
      else if (elig_c[i] && age_q[i] != AGE_MAX)  age_d[i] = age_q[i] + AGE_W'(1);
      aged_d[i] = (age_d[i] == AGE_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) age_q[i] <= '0;
      aged_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) age_q[i] <= age_d[i];
      aged_q <= aged_d;
    end
  end

  assign aged_c     = aged_q;
  assign bus.aged_o = aged_q;
`else
  logic unused_age;
  assign unused_age = ^AGE_MAX;
  assign aged_c     = '0;
  assign bus.aged_o = '0;
`endif

  // Grant pulses, path hold counters and crossbar selects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      zero_q  <= '0;
      busy_q  <= '0;
      sel_q   <= '0;
      rr_ptr  <= '0;
      for (int j = 0; j < NUM_PORTS; j++) busy_cnt[j] <= '0;
    end else begin
      grant_q <= gnt_d;
      zero_q  <= zero_c;
      rr_ptr  <= rr_d;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (claim_d[j]) begin
          busy_cnt[j]                    <= XFER_LD;
          sel_q[NUM_PORTS*j +: NUM_PORTS] <= sel_d[j];
          busy_q[j]                      <= 1'b1;
        end else if (busy_cnt[j] != '0) begin
          busy_cnt[j] <= busy_cnt[j] - CNT_W'(1);
          if (busy_cnt[j] == CNT_W'(1)) begin
            sel_q[NUM_PORTS*j +: NUM_PORTS] <= '0;
            busy_q[j]                      <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.grant_o    = grant_q;
  assign bus.zero_tgt_o = zero_q;
  assign bus.out_busy_o = busy_q;
  assign bus.out_sel_o  = sel_q;
endmodule

// File: tb/tb_switch_egress_scheduler.sv
// Directed self-checking bench for switch_egress_scheduler (XFER_CYCLES=2).
module tb_switch_egress_scheduler;
  localparam int unsigned NP = 4;
`ifdef STARVE_GUARD_EN
  localparam int unsigned AGE_LIM = 4;
`else
  localparam int unsigned AGE_LIM = 16;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_egress_if #(.NUM_PORTS(NP)) bus ();

  switch_egress_scheduler #(
    .NUM_PORTS  (NP),
    .XFER_CYCLES(2),
    .AGE_LIMIT  (AGE_LIM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [15:0] t, input logic [3:0] p);
    bus.req_i    = r;
    bus.target_i = t;
    bus.prio_i   = p;
  endtask

  task automatic do_reset();
    drive(4'b0, 16'h0, 4'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int aged_at;
    int gnt_at;
    int g0;
    drive(4'b0, 16'h0, 4'b0);
    tick();
    tick();
    check("rst_grant", 32'(bus.grant_o), 32'h0);
    check("rst_sel",   32'(bus.out_sel_o), 32'h0);
    check("rst_busy",  32'(bus.out_busy_o), 32'h0);
    check("rst_aged",  32'(bus.aged_o), 32'h0);
    check("rst_zero",  32'(bus.zero_tgt_o), 32'h0);
    rst_n = 1'b1;

    // Reset mid-transfer drops the egress 2 path without a clock edge
    drive(4'b0001, 16'h0004, 4'b0);
    tick();
    check("mid_grant", 32'(bus.grant_o), 32'h1);
    check("mid_sel",   32'(bus.out_sel_o), 32'h0100);
    drive(4'b0, 16'h0, 4'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_grant", 32'(bus.grant_o), 32'h0);
    check("async_sel",   32'(bus.out_sel_o), 32'h0);
    check("async_busy",  32'(bus.out_busy_o), 32'h0);
    drive(4'b0010, 16'h0010, 4'b0);
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_grant", 32'(bus.grant_o), 32'h2);
    check("post_rst_sel",   32'(bus.out_sel_o), 32'h0002);

    // Unicast contention on egress 1 between ingress 0 and 3
    do_reset();
    drive(4'b1001, 16'h2002, 4'b0);
    tick();
    check("uc_grant0", 32'(bus.grant_o), 32'h1);
    check("uc_sel0",   32'(bus.out_sel_o), 32'h0010);
    drive(4'b1000, 16'h2002, 4'b0);
    tick();
    check("uc_hold_grant", 32'(bus.grant_o), 32'h0);
    check("uc_hold_sel",   32'(bus.out_sel_o), 32'h0010);
    tick();
    check("uc_free_sel",  32'(bus.out_sel_o), 32'h0);
    check("uc_free_busy", 32'(bus.out_busy_o), 32'h0);
    check("uc_free_grant", 32'(bus.grant_o), 32'h0);
    tick();
    check("uc_grant3", 32'(bus.grant_o), 32'h8);
    check("uc_sel3",   32'(bus.out_sel_o), 32'h0080);
    drive(4'b0, 16'h0, 4'b0);

    // High priority ingress 2 beats ingress 0 despite rr_ptr=0
    do_reset();
    drive(4'b0101, 16'h0101, 4'b0100);
    tick();
    check("prio_grant", 32'(bus.grant_o), 32'h4);
    check("prio_sel",   32'(bus.out_sel_o), 32'h0004);
    drive(4'b0001, 16'h0001, 4'b0);
    tick();
    tick();
    tick();
    check("prio_late_grant", 32'(bus.grant_o), 32'h1);
    check("prio_late_sel",   32'(bus.out_sel_o), 32'h0001);
    drive(4'b0, 16'h0, 4'b0);

    // Multicast 1101 waits for busy egress 2, then is allocated in one grant
    do_reset();
    drive(4'b0001, 16'h0004, 4'b0);
    tick();
    drive(4'b0010, 16'h00D0, 4'b0);
    tick();
    check("mc_wait_grant", 32'(bus.grant_o), 32'h0);
    check("mc_wait_busy",  32'(bus.out_busy_o), 32'h4);
    tick();
    check("mc_free_grant", 32'(bus.grant_o), 32'h0);
    check("mc_free_busy",  32'(bus.out_busy_o), 32'h0);
    tick();
    drive(4'b0, 16'h0, 4'b0);
    check("mc_grant", 32'(bus.grant_o), 32'h2);
    check("mc_busy",  32'(bus.out_busy_o), 32'hD);
    check("mc_sel",   32'(bus.out_sel_o), 32'h2202);
    tick();
    check("mc_busy2", 32'(bus.out_busy_o), 32'hD);
    tick();
    check("mc_done_busy", 32'(bus.out_busy_o), 32'h0);

    // Zero target mask flags and is never granted
    drive(4'b0010, 16'h0000, 4'b0);
    tick();
    check("zt_flag",  32'(bus.zero_tgt_o), 32'h2);
    check("zt_grant", 32'(bus.grant_o), 32'h0);
    check("zt_busy",  32'(bus.out_busy_o), 32'h0);
    drive(4'b0, 16'h0, 4'b0);
    tick();
    check("zt_pulse_end", 32'(bus.zero_tgt_o), 32'h0);

    // Wide multicast against staggered continuous unicasts
    do_reset();
    drive(4'b0010, 16'h421F, 4'b0);
    tick();
    drive(4'b0110, 16'h421F, 4'b0);
    tick();
    drive(4'b1110, 16'h421F, 4'b0);
    tick();
    drive(4'b1111, 16'h421F, 4'b0);
    aged_at = -1;
    gnt_at  = -1;
    g0      = 0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (bus.aged_o[0] && aged_at < 0) aged_at = c;
      if (bus.grant_o[0] && gnt_at < 0) gnt_at = c;
      if (bus.grant_o[0]) g0++;
    end
`ifdef STARVE_GUARD_EN
    check("sg_aged_cycle", 32'(aged_at), 32'd4);
    check("sg_grant_in_window", 32'((gnt_at > aged_at) && (gnt_at <= aged_at + 3)), 32'd1);
`else
    check("starve_no_grant", 32'(g0), 32'd0);
    check("starve_no_aged",  32'(aged_at), 32'hFFFF_FFFF);
`endif
    drive(4'b0, 16'h0, 4'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
